// File: rtl/scan_sel_sequencer_pkg.sv
// Shared types and sizing helpers for the channel scan sequencer.
package scan_sel_sequencer_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_BLANK
    } state_t;

    // The counter must hold the larger of the dwell and blank terminal
    // counts. A floor of 2 keeps the counter at least 1 bit wide.
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = 2;
        if (dwell > m) m = dwell;
        if (blank > m) m = blank;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/scan_sel_sequencer_next_set_finder.sv
// Rotating priority encoder: finds the first set mask bit after cur,
// wrapping 7->0, with cur itself checked last.
module next_set_finder
    import scan_sel_sequencer_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              any,
    output logic              wrap
);

    // Walk cur+1 .. cur+8. The 3-bit sum wraps naturally, so the eighth
    // step lands back on cur.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        any  = |mask;
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/scan_sel_sequencer.sv
// Time-multiplexed channel scanner driving a 3-to-8 decoder select.
// Each enabled channel is shown for DWELL cycles, then blanked for
// BLANK cycles. frame_done pulses when the scan wraps to a lower-or-equal
// channel index.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | scan stopped, sel=0, waiting for en with a non-empty mask
// ST_DWELL | sel driven, sel_valid high, counting down the dwell time
// ST_BLANK | sel held, sel_valid low, counting down the blanking gap
module scan_sel_sequencer
    import scan_sel_sequencer_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] mask,
    input  logic              hold,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_valid,
    output logic              frame_done
);

    localparam int CNT_W = cnt_width(DWELL, BLANK);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] find_cur;
    logic [SEL_W-1:0] nxt;
    logic             any;
    logic             wrap;
    logic             advance;

    // From IDLE, searching after channel 7 yields the lowest set bit.
    assign find_cur = (state == ST_IDLE) ? SEL_W'(NUM_CH - 1) : sel;

    next_set_finder u_finder (
        .mask (mask),
        .cur  (find_cur),
        .nxt  (nxt),
        .any  (any),
        .wrap (wrap)
    );

    // Move to the next channel when the last timed phase of a channel
    // expires; with no blanking that phase is the dwell itself.
    always_comb begin
        advance = 1'b0;
        if (en && !hold && cnt == '0) begin
            if (state == ST_BLANK)
                advance = 1'b1;
            else if (state == ST_DWELL && BLANK == 0)
                advance = 1'b1;
        end
    end

    // Scan FSM; the timer is a down-counter loaded with the phase's last
    // count and compared against zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sel_valid  <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (advance) begin
                if (!any) begin
                    state     <= ST_IDLE;
                    sel       <= '0;
                    sel_valid <= 1'b0;
                    cnt       <= '0;
                end else begin
                    state      <= ST_DWELL;
                    sel        <= nxt;
                    sel_valid  <= 1'b1;
                    cnt        <= DWELL_LAST;
                    frame_done <= wrap;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        sel_valid <= 1'b0;
                        if (en && any) begin
                            state     <= ST_DWELL;
                            sel       <= nxt;
                            sel_valid <= 1'b1;
                            cnt       <= DWELL_LAST;
                        end
                    end
                    ST_DWELL: begin
                        if (!en) begin
                            state     <= ST_IDLE;
                            sel       <= '0;
                            sel_valid <= 1'b0;
                            cnt       <= '0;
                        end else if (hold) begin
                            cnt <= cnt;
                        end else if (cnt == '0) begin
                            state     <= ST_BLANK;
                            sel_valid <= 1'b0;
                            cnt       <= BLANK_LAST;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        sel_valid <= 1'b0;
                        if (!en) begin
                            state <= ST_IDLE;
                            sel   <= '0;
                            cnt   <= '0;
                        end else if (!hold) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        sel       <= '0;
                        sel_valid <= 1'b0;
                        cnt       <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed bench for scan_sel_sequencer (DWELL=4, BLANK=1) and its
// rotating priority encoder.
module tb_scan_sel_sequencer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] mask;
    logic       hold;
    logic [2:0] sel;
    logic       sel_valid;
    logic       frame_done;

    logic [7:0] f_mask;
    logic [2:0] f_cur;
    logic [2:0] f_nxt;
    logic       f_any;
    logic       f_wrap;

    int checks;
    int failures;

    scan_sel_sequencer #(.DWELL(4), .BLANK(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mask       (mask),
        .hold       (hold),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .frame_done (frame_done)
    );

    next_set_finder u_nsf (
        .mask (f_mask),
        .cur  (f_cur),
        .nxt  (f_nxt),
        .any  (f_any),
        .wrap (f_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int s, input int v, input int fd);
        check({tag, ".sel"}, int'(sel), s);
        check({tag, ".valid"}, int'(sel_valid), v);
        check({tag, ".frame_done"}, int'(frame_done), fd);
    endtask

    // One channel period: four dwell cycles then one blank cycle.
    task automatic expect_channel(input int ch, input int fd_first);
        for (int k = 0; k < 4; k++) begin
            step();
            check_out($sformatf("ch%0d_dwell%0d", ch, k), ch, 1, (k == 0) ? fd_first : 0);
        end
        step();
        check_out($sformatf("ch%0d_blank", ch), ch, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        hold  = 1'b0;
        mask  = 8'h00;
        step();
        check_out("reset", 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic finder_vec(input logic [7:0] m, input logic [2:0] c,
                              input int exp_nxt, input int exp_any, input int exp_wrap);
        f_mask = m;
        f_cur  = c;
        #1;
        if (exp_any != 0) begin
            check($sformatf("nsf_nxt_%02h_%0d", m, c), int'(f_nxt), exp_nxt);
            check($sformatf("nsf_wrap_%02h_%0d", m, c), int'(f_wrap), exp_wrap);
        end
        check($sformatf("nsf_any_%02h_%0d", m, c), int'(f_any), exp_any);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        hold     = 1'b0;
        mask     = 8'h00;
        f_mask   = 8'h00;
        f_cur    = 3'd0;

        finder_vec(8'hFF, 3'd3, 4, 1, 0);
        finder_vec(8'hFF, 3'd7, 0, 1, 1);
        finder_vec(8'hA4, 3'd7, 2, 1, 1);
        finder_vec(8'hA4, 3'd2, 5, 1, 0);
        finder_vec(8'hA4, 3'd5, 7, 1, 0);
        finder_vec(8'h08, 3'd3, 3, 1, 1);
        finder_vec(8'h01, 3'd0, 0, 1, 1);
        finder_vec(8'hFD, 3'd1, 2, 1, 0);
        finder_vec(8'h00, 3'd5, 0, 0, 0);

        // Full mask: 0..7 then wrap to 0 with frame_done.
        do_reset();
        en   = 1'b1;
        mask = 8'hFF;
        for (int ch = 0; ch < 8; ch++) expect_channel(ch, 0);
        expect_channel(0, 1);

        // Sparse mask: 2,5,7,2,5 with frame_done only on 7->2.
        do_reset();
        en   = 1'b1;
        mask = 8'hA4;
        expect_channel(2, 0);
        expect_channel(5, 0);
        expect_channel(7, 0);
        expect_channel(2, 1);
        expect_channel(5, 0);

        // Single channel: stays at 3, frame_done every period after the first.
        do_reset();
        en   = 1'b1;
        mask = 8'h08;
        expect_channel(3, 0);
        expect_channel(3, 1);
        expect_channel(3, 1);

        // Empty mask keeps the scanner idle; first set bit starts it next edge.
        do_reset();
        en   = 1'b1;
        mask = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            check_out($sformatf("empty%0d", i), 0, 0, 0);
        end
        mask = 8'h01;
        step();
        check_out("empty_start", 0, 1, 0);

        // Abort on en low during the dwell of channel 4, then restart.
        do_reset();
        en   = 1'b1;
        mask = 8'hFF;
        for (int ch = 0; ch < 4; ch++) expect_channel(ch, 0);
        step();
        check_out("abort_pre", 4, 1, 0);
        en = 1'b0;
        step();
        check_out("abort", 0, 0, 0);
        en   = 1'b1;
        mask = 8'h30;
        step();
        check_out("restart", 4, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("restart_dwell%0d", k), 4, 1, 0);
        end
        step();
        check_out("restart_blank", 4, 0, 0);
        rst_n = 1'b0;
        step();
        check_out("mid_blank_reset", 0, 0, 0);
        rst_n = 1'b1;
        step();
        check_out("post_reset_start", 4, 1, 0);

        // Hold on channel 1 stretches its dwell to 7 cycles; clearing bit 1
        // during the hold does not cut the dwell short.
        do_reset();
        en   = 1'b1;
        mask = 8'hFF;
        expect_channel(0, 0);
        step();
        check_out("hold_first", 1, 1, 0);
        hold = 1'b1;
        mask = 8'hFD;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("held%0d", k), 1, 1, 0);
        end
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("post_hold%0d", k), 1, 1, 0);
        end
        step();
        check_out("post_hold_blank", 1, 0, 0);
        expect_channel(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
